bus_arbiter_rr: RTL and testbench

Parametrised successor to the two-core system bus. Connects NUM_CORES cores to one gpiomem/RAM port. Round-robin arbitration with a registered grant, an optional hold-timeout preemption, and a one-cycle bus turnaround between owners. Instantiated in top between the core array and gpiomem.

---
 rtl/bus_arbiter_rr.sv | 135 +++++++++++++
 tb/tb_bus_arbiter_rr.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin NUM_CORES-to-one bus arbiter with hold timeout and turnaround
module bus_arbiter_rr #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int MAX_HOLD  = 16,
    localparam int OW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_request,
    output logic [NUM_CORES-1:0]        core_grant,
    input  logic [NUM_CORES-1:0]        core_rw,
    input  logic [NUM_CORES*ADDR_W-1:0] core_address,
    input  logic [NUM_CORES*DATA_W-1:0] core_data_in,
    output logic [NUM_CORES*DATA_W-1:0] core_data_out,
    output logic [ADDR_W-1:0]           RAM_address,
    output logic [DATA_W-1:0]           RAM_data_in,
    input  logic [DATA_W-1:0]           RAM_data_out,
    output logic                        rw,
    output logic [OW-1:0]               owner,
    output logic                        busy
);

    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
    // Saturating at MAX_HOLD-1 keeps the timeout armed after a long solo hold.
    localparam logic [HW-1:0] HOLD_SAT = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [OW-1:0]          last_owner;
    logic [OW-1:0]          sel;
    logic [HW-1:0]          hold_cnt;
    logic                   any_req;
    logic                   others_req;
    logic                   timeout;
    logic [ADDR_W-1:0]      addr_arr [NUM_CORES];
    logic [DATA_W-1:0]      din_arr  [NUM_CORES];

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            addr_arr[i] = core_address[i*ADDR_W +: ADDR_W];
            din_arr[i]  = core_data_in[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        int  idx;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = (int'(last_owner) + k) % NUM_CORES;
            if (!found && core_request[idx]) begin
                sel   = OW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req    = |core_request;
    assign others_req = |(core_request & ~core_grant);
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT) && others_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            core_grant <= '0;
            hold_cnt   <= '0;
            last_owner <= OW'(NUM_CORES - 1);
            owner      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        core_grant <= {{(NUM_CORES-1){1'b0}}, 1'b1} << sel;
                        owner      <= sel;
                        hold_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                    if (state_nxt == RELEASE) begin
                        core_grant <= '0;
                    end
                end
                RELEASE: begin
                    last_owner <= owner;
                end
                default: begin
                    core_grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (!core_request[owner] || timeout) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == GRANT);
        rw            = 1'b0;
        RAM_address   = '0;
        RAM_data_in   = '0;
        core_data_out = '0;
        if (state == GRANT) begin
            RAM_address = addr_arr[owner];
            RAM_data_in = din_arr[owner];
            rw          = core_rw[owner] & core_request[owner];
            for (int i = 0; i < NUM_CORES; i++) begin
                if (OW'(i) == owner) begin
                    core_data_out[i*DATA_W +: DATA_W] = RAM_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed vectors plus randomized model check for bus_arbiter_rr
module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MH = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    core_request;
    logic [N-1:0]    core_grant;
    logic [N-1:0]    core_rw;
    logic [N*AW-1:0] core_address;
    logic [N*DW-1:0] core_data_in;
    logic [N*DW-1:0] core_data_out;
    logic [AW-1:0]   RAM_address;
    logic [DW-1:0]   RAM_data_in;
    logic [DW-1:0]   RAM_data_out;
    logic            rw;
    logic [1:0]      owner;
    logic            busy;

    bus_arbiter_rr #(
        .NUM_CORES(N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_request (core_request),
        .core_grant   (core_grant),
        .core_rw      (core_rw),
        .core_address (core_address),
        .core_data_in (core_data_in),
        .core_data_out(core_data_out),
        .RAM_address  (RAM_address),
        .RAM_data_in  (RAM_data_in),
        .RAM_data_out (RAM_data_out),
        .rw           (rw),
        .owner        (owner),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grant;
        int           own;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;

    int m_own;
    int m_cool;
    int m_last;
    int m_held;
    int m_disp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [N-1:0] r, input logic [N-1:0] g, input int o);
        vec_t v;
        v.req   = r;
        v.grant = g;
        v.own   = o;
        tv.push_back(v);
    endfunction

    function automatic void model_reset();
        m_own  = -1;
        m_cool = 0;
        m_last = N - 1;
        m_held = 0;
        m_disp = 0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r);
        logic [N-1:0] others;
        if (m_own >= 0) begin
            m_held++;
            others = r & ~(N'(1) << m_own);
            if (!r[m_own] || (m_held >= MH && others != 0)) begin
                m_last = m_own;
                m_own  = -1;
                m_cool = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_own < 0 && r[c]) begin
                    m_own  = c;
                    m_disp = c;
                    m_held = 0;
                end
            end
        end
    endfunction

    task automatic check_model(input int cyc);
        logic [N-1:0]    eg;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ed;
        logic            erw;
        logic [N*DW-1:0] edo;
        eg = '0; ea = '0; ed = '0; erw = 1'b0; edo = '0;
        if (m_own >= 0) begin
            eg  = N'(1) << m_own;
            ea  = core_address[m_own*AW +: AW];
            ed  = core_data_in[m_own*DW +: DW];
            erw = core_rw[m_own] & core_request[m_own];
            edo[m_own*DW +: DW] = RAM_data_out;
        end
        chk($sformatf("rnd%0d grant", cyc), 64'(core_grant), 64'(eg));
        chk($sformatf("rnd%0d busy", cyc), 64'(busy), 64'(m_own >= 0));
        chk($sformatf("rnd%0d owner", cyc), 64'(owner), 64'(m_disp));
        chk($sformatf("rnd%0d rw", cyc), 64'(rw), 64'(erw));
        chk($sformatf("rnd%0d addr", cyc), 64'(RAM_address), 64'(ea));
        chk($sformatf("rnd%0d din", cyc), 64'(RAM_data_in), 64'(ed));
        chk($sformatf("rnd%0d dout", cyc), 64'(core_data_out), 64'(edo));
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        core_request = '0;
        core_rw      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        core_request = '0;
        core_rw      = '0;
        core_address = '0;
        core_data_in = '0;
        RAM_data_out = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst grant", 64'(core_grant), 64'(0));
        chk("rst rw", 64'(rw), 64'(0));
        chk("rst owner", 64'(owner), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst addr", 64'(RAM_address), 64'(0));
        chk("rst dout", 64'(core_data_out), 64'(0));
        reset = 1'b0;

        add(4'b0011, 4'b0001, 0); add(4'b0011, 4'b0001, 0);
        add(4'b0010, 4'b0000, 0); add(4'b0010, 4'b0000, 0);
        add(4'b0010, 4'b0010, 1); add(4'b1111, 4'b0010, 1);
        add(4'b1111, 4'b0010, 1); add(4'b1101, 4'b0000, 1);
        add(4'b1101, 4'b0000, 1); add(4'b1111, 4'b0100, 2);
        add(4'b1111, 4'b0100, 2); add(4'b1111, 4'b0100, 2);
        add(4'b1011, 4'b0000, 2); add(4'b1011, 4'b0000, 2);
        add(4'b1111, 4'b1000, 3); add(4'b1111, 4'b1000, 3);
        add(4'b1111, 4'b1000, 3); add(4'b0111, 4'b0000, 3);
        add(4'b0111, 4'b0000, 3); add(4'b1111, 4'b0001, 0);
        add(4'b1111, 4'b0001, 0); add(4'b1111, 4'b0001, 0);
        add(4'b1110, 4'b0000, 0); add(4'b1110, 4'b0000, 0);
        add(4'b0001, 4'b0001, 0); add(4'b0011, 4'b0001, 0);
        add(4'b0011, 4'b0001, 0); add(4'b0011, 4'b0001, 0);
        add(4'b0011, 4'b0000, 0); add(4'b0011, 4'b0000, 0);
        add(4'b0011, 4'b0010, 1); add(4'b0001, 4'b0000, 1);
        add(4'b0001, 4'b0000, 1); add(4'b0001, 4'b0001, 0);

        core_address[0 +: AW]  = 9'h010;
        core_data_in[0 +: DW]  = 8'hA5;
        core_address[AW +: AW] = 9'h055;
        core_data_in[DW +: DW] = 8'h3E;
        core_rw                = 4'b0001;
        for (int i = 0; i < tv.size(); i++) begin
            core_request = tv[i].req;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d grant", i), 64'(core_grant), 64'(tv[i].grant));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tv[i].grant != 0));
            chk($sformatf("vec%0d owner", i), 64'(owner), 64'(tv[i].own));
            if (tv[i].grant == 0) begin
                chk($sformatf("vec%0d idle rw", i), 64'(rw), 64'(0));
                chk($sformatf("vec%0d idle addr", i), 64'(RAM_address), 64'(0));
            end
            if (i == 0) begin
                chk("c0 write addr", 64'(RAM_address), 64'(9'h010));
                chk("c0 write data", 64'(RAM_data_in), 64'(8'hA5));
                chk("c0 write rw", 64'(rw), 64'(1));
            end
            if (i == 4) begin
                chk("c1 addr", 64'(RAM_address), 64'(9'h055));
                chk("c1 data", 64'(RAM_data_in), 64'(8'h3E));
                chk("c1 rw", 64'(rw), 64'(0));
            end
        end

        for (int i = 0; i < 20; i++) begin
            core_request = 4'b0001;
            @(posedge clk);
            #1;
            chk($sformatf("solo%0d grant", i), 64'(core_grant), 64'(4'b0001));
            chk($sformatf("solo%0d busy", i), 64'(busy), 64'(1));
        end
        core_request = 4'b0000;
        @(posedge clk);
        #1;
        chk("solo drop grant", 64'(core_grant), 64'(0));
        chk("solo drop busy", 64'(busy), 64'(0));

        do_reset();
        core_request           = 4'b0010;
        core_address[AW +: AW] = 9'h1F0;
        core_rw                = 4'b0000;
        RAM_data_out           = 8'h3C;
        @(posedge clk);
        #1;
        chk("rd grant", 64'(core_grant), 64'(4'b0010));
        chk("rd owner", 64'(owner), 64'(1));
        chk("rd addr", 64'(RAM_address), 64'(9'h1F0));
        chk("rd c1 dout", 64'(core_data_out[DW +: DW]), 64'(8'h3C));
        chk("rd c0 dout", 64'(core_data_out[0 +: DW]), 64'(0));
        chk("rd rw", 64'(rw), 64'(0));
        core_rw = 4'b0010;
        #1;
        chk("wr rw", 64'(rw), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async grant", 64'(core_grant), 64'(0));
        chk("async rw", 64'(rw), 64'(0));
        chk("async busy", 64'(busy), 64'(0));
        chk("async dout", 64'(core_data_out), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        core_request = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 4) == 0) core_request[b] = ~core_request[b];
            end
            core_rw      = N'($urandom());
            core_address = (N*AW)'({$urandom(), $urandom()});
            core_data_in = $urandom();
            RAM_data_out = DW'($urandom());
            @(negedge clk);
            check_model(c);
            @(posedge clk);
            model_step(core_request);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
